cus19_alu_sched: RTL and testbench

- Sequencer/arbiter that shares the single combinational cus19_alu between two requesters: requester 0 (core execute stage) and requester 1 (crypto accelerator).
- Arbitrates between the requesters with round-robin priority and drives the ALU operand, function and enable inputs.
- Registers the ALU result and returns it over a valid/ready response handshake.
- Intercepts illegal function codes and divide-by-zero so the ALU never receives them.

---
 rtl/cus19_alu_sched.sv | 170 +++++++++++++++++
 tb/tb_cus19_alu_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cus19_alu_sched.sv
// cus19_alu_sched: round-robin sequencer that shares one combinational
// cus19_alu between the core execute stage (requester 0) and the crypto
// accelerator (requester 1). It grants one request at a time and gives the
// ALU a single execute cycle. It registers the result and returns it over a
// per-requester valid/ready response. Illegal function codes and divide by
// zero are caught here, so the ALU never sees them.
module cus19_alu_sched #(
  parameter int Data_Width   = 8,
  parameter int Result_Width = 16,
  parameter int Cnt_Width    = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [1:0]              req_valid_in,
  output logic [1:0]              req_ready_out,
  input  logic [Data_Width-1:0]   req0_op1_in,
  input  logic [Data_Width-1:0]   req0_op2_in,
  input  logic [3:0]              req0_funct_in,
  input  logic [Data_Width-1:0]   req1_op1_in,
  input  logic [Data_Width-1:0]   req1_op2_in,
  input  logic [3:0]              req1_funct_in,
  output logic [1:0]              rsp_valid_out,
  input  logic [1:0]              rsp_ready_in,
  output logic [Result_Width-1:0] rsp_result_out,
  output logic                    rsp_err_out,
  output logic [Data_Width-1:0]   alu_op1_out,
  output logic [Data_Width-1:0]   alu_op2_out,
  output logic [3:0]              alu_funct_out,
  output logic                    alu_en_out,
  input  logic [Result_Width-1:0] alu_result_in,
  output logic                    busy_out,
  output logic [Cnt_Width-1:0]    op_count_out
);

  // ALU function encoding: codes 0..9 are implemented, DIV is code 3.
  localparam logic [3:0] FUNCT_DIV        = 4'b0011;
  localparam logic [3:0] FUNCT_LAST_LEGAL = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_reg;
  logic                    last_grant_reg;
  logic                    id_reg;
  logic [Data_Width-1:0]   op1_reg;
  logic [Data_Width-1:0]   op2_reg;
  logic [3:0]              funct_reg;
  logic                    alu_en_reg;
  logic [Result_Width-1:0] result_reg;
  logic                    err_reg;
  logic [1:0]              rsp_valid_reg;
  logic                    busy_reg;
  logic [Cnt_Width-1:0]    op_count_reg;

  logic [1:0]              grant_next;
  logic                    win_id_next;
  logic [Data_Width-1:0]   win_op1_next;
  logic [Data_Width-1:0]   win_op2_next;
  logic [3:0]              win_funct_next;
  logic                    handshake;
  logic                    rsp_fire;

  // An operation is legal when its code is implemented and it is not a divide by zero.
  function automatic logic op_legal(input logic [3:0] funct, input logic [Data_Width-1:0] op2);
    return (funct <= FUNCT_LAST_LEGAL) && !((funct == FUNCT_DIV) && (op2 == '0));
  endfunction

  // Grant is only offered in IDLE. When both requesters contend, the one that
  // did not win last time gets the grant.
  always_comb begin
    grant_next = 2'b00;
    if (state_reg == IDLE) begin
      case (req_valid_in)
        2'b01:   grant_next = 2'b01;
        2'b10:   grant_next = 2'b10;
        2'b11:   grant_next = last_grant_reg ? 2'b01 : 2'b10;
        default: grant_next = 2'b00;
      endcase
    end
  end

  assign win_id_next    = grant_next[1];
  assign win_op1_next   = win_id_next ? req1_op1_in   : req0_op1_in;
  assign win_op2_next   = win_id_next ? req1_op2_in   : req0_op2_in;
  assign win_funct_next = win_id_next ? req1_funct_in : req0_funct_in;
  assign handshake      = |grant_next;
  assign rsp_fire       = (state_reg == RESP) && rsp_ready_in[id_reg];

  // Per-requester handshake signals. Ready is also held low while reset is
  // asserted, so that all outputs read zero during reset.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign req_ready_out[gi] = grant_next[gi] & req_valid_in[gi] & rst_n_in;
    assign rsp_valid_out[gi] = rsp_valid_reg[gi];
  end

  assign alu_op1_out    = op1_reg;
  assign alu_op2_out    = op2_reg;
  assign alu_funct_out  = funct_reg;
  assign alu_en_out     = alu_en_reg;
  assign rsp_result_out = result_reg;
  assign rsp_err_out    = err_reg;
  assign busy_out       = busy_reg;
  assign op_count_out   = op_count_reg;

  // Main sequencer: accept in IDLE, run the ALU for one cycle in EXEC, then
  // hold the response in RESP until its owner takes it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      id_reg         <= 1'b0;
      op1_reg        <= '0;
      op2_reg        <= '0;
      funct_reg      <= '0;
      alu_en_reg     <= 1'b0;
      result_reg     <= '0;
      err_reg        <= 1'b0;
      rsp_valid_reg  <= 2'b00;
      busy_reg       <= 1'b0;
      op_count_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (handshake) begin
            op1_reg        <= win_op1_next;
            op2_reg        <= win_op2_next;
            funct_reg      <= win_funct_next;
            id_reg         <= win_id_next;
            last_grant_reg <= win_id_next;
            // The enable is decided here, so it is high for exactly the EXEC cycle.
            alu_en_reg     <= op_legal(win_funct_next, win_op2_next);
            busy_reg       <= 1'b1;
            state_reg      <= EXEC;
          end
        end
        EXEC: begin
          alu_en_reg <= 1'b0;
          if (op_legal(funct_reg, op2_reg)) begin
            result_reg <= alu_result_in;
            err_reg    <= 1'b0;
          end else begin
            result_reg <= {Result_Width{1'b1}};
            err_reg    <= 1'b1;
          end
          rsp_valid_reg <= id_reg ? 2'b10 : 2'b01;
          state_reg     <= RESP;
        end
        RESP: begin
          // Only the owner's ready completes the response; the other bit is ignored.
          if (rsp_fire) begin
            rsp_valid_reg <= 2'b00;
            op_count_reg  <= op_count_reg + Cnt_Width'(1);
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          alu_en_reg    <= 1'b0;
          rsp_valid_reg <= 2'b00;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cus19_alu_sched.sv
// Bench for cus19_alu_sched: a behavioural ALU drives alu_result_in. A
// reference model tracks the round-robin winner, the expected result and
// error, and the completed-operation count. The bench combines directed
// scenarios with randomized transactions.
module tb_cus19_alu_sched;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [1:0]  req_valid_in;
  logic [1:0]  req_ready_out;
  logic [7:0]  req0_op1_in, req0_op2_in, req1_op1_in, req1_op2_in;
  logic [3:0]  req0_funct_in, req1_funct_in;
  logic [1:0]  rsp_valid_out;
  logic [1:0]  rsp_ready_in;
  logic [15:0] rsp_result_out;
  logic        rsp_err_out;
  logic [7:0]  alu_op1_out, alu_op2_out;
  logic [3:0]  alu_funct_out;
  logic        alu_en_out;
  logic [15:0] alu_result_in;
  logic        busy_out;
  logic [15:0] op_count_out;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          m_last  = 1'b1;
  int          m_count = 0;

  always #5 clk_in = ~clk_in;

  cus19_alu_sched #(.Data_Width(8), .Result_Width(16), .Cnt_Width(16)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req0_op1_in(req0_op1_in), .req0_op2_in(req0_op2_in), .req0_funct_in(req0_funct_in),
    .req1_op1_in(req1_op1_in), .req1_op2_in(req1_op2_in), .req1_funct_in(req1_funct_in),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
    .rsp_result_out(rsp_result_out), .rsp_err_out(rsp_err_out),
    .alu_op1_out(alu_op1_out), .alu_op2_out(alu_op2_out),
    .alu_funct_out(alu_funct_out), .alu_en_out(alu_en_out),
    .alu_result_in(alu_result_in), .busy_out(busy_out), .op_count_out(op_count_out)
  );

  // Behavioural cus19_alu: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR, 8 SHL, 9 SHR
  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    logic [15:0] wa, wb;
    wa = {8'h00, a};
    wb = {8'h00, b};
    case (f)
      4'd0: return wa + wb;
      4'd1: return wa - wb;
      4'd2: return wa * wb;
      4'd3: return (b == 0) ? 16'h0 : wa / wb;
      4'd4: return (b == 0) ? 16'h0 : wa % wb;
      4'd5: return wa & wb;
      4'd6: return wa | wb;
      4'd7: return wa ^ wb;
      4'd8: return wa << b[2:0];
      4'd9: return wa >> b[2:0];
      default: return 16'h0;
    endcase
  endfunction

  assign alu_result_in = alu_en_out ? alu_f(alu_op1_out, alu_op2_out, alu_funct_out) : 16'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round robin: a lone requester wins; on contention the one not granted last time wins.
  function automatic bit pick(input logic [1:0] v, input bit last);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
    return !last;
  endfunction

  task automatic set_req(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    if (id) begin req1_op1_in = a; req1_op2_in = b; req1_funct_in = f; end
    else    begin req0_op1_in = a; req0_op2_in = b; req0_funct_in = f; end
  endtask

  task automatic rand_req(input bit id);
    logic [7:0] b;
    b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
    set_req(id, 8'($urandom), b, 4'($urandom_range(0, 15)));
  endtask

  // One full transaction. Call right after a negedge with the DUT in IDLE and
  // request inputs set; returns at a negedge with the DUT back in IDLE.
  task automatic do_txn(input int bp, input bit refresh, output bit gid);
    bit          id;
    logic [7:0]  a, b;
    logic [3:0]  f;
    logic        lg;
    logic [15:0] er;
    logic [1:0]  oh;
    #1;
    id = pick(req_valid_in, m_last);
    oh = id ? 2'b10 : 2'b01;
    a  = id ? req1_op1_in   : req0_op1_in;
    b  = id ? req1_op2_in   : req0_op2_in;
    f  = id ? req1_funct_in : req0_funct_in;
    lg = (f <= 4'd9) && !(f == 4'd3 && b == 8'h00);
    er = lg ? alu_f(a, b, f) : 16'hFFFF;
    check("grant_ready", req_ready_out, oh);
    check("busy_idle", busy_out, 0);
    @(negedge clk_in);
    if (refresh) rand_req(id);
    #1;
    check("alu_en_exec", alu_en_out, lg);
    check("ready_exec", req_ready_out, 2'b00);
    check("busy_exec", busy_out, 1);
    check("alu_op1", alu_op1_out, a);
    check("alu_op2", alu_op2_out, b);
    check("alu_funct", alu_funct_out, f);
    @(negedge clk_in);
    rsp_ready_in = (bp == 0) ? oh : (2'($urandom) & ~oh);
    #1;
    check("rsp_valid", rsp_valid_out, oh);
    check("rsp_result", rsp_result_out, er);
    check("rsp_err", rsp_err_out, !lg);
    check("alu_en_resp", alu_en_out, 0);
    for (int i = 1; i <= bp; i++) begin
      @(negedge clk_in);
      rsp_ready_in = (i == bp) ? oh : (2'($urandom) & ~oh);
      #1;
      check("bp_valid", rsp_valid_out, oh);
      check("bp_result", rsp_result_out, er);
      check("bp_err", rsp_err_out, !lg);
      check("bp_ready", req_ready_out, 2'b00);
    end
    @(negedge clk_in);
    rsp_ready_in = 2'b00;
    m_count = m_count + 1;
    m_last  = id;
    #1;
    check("op_count", op_count_out, 16'(m_count));
    check("rsp_done", rsp_valid_out, 2'b00);
    check("busy_done", busy_out, 0);
    $display("txn id=%0d funct=%0d op1=%0d op2=%0d result=%0h err=%0d count=%0d",
             id, f, a, b, er, !lg, m_count);
    gid = id;
  endtask

  initial begin
    bit g, prev;
    rst_n_in = 1'b0;
    req_valid_in = 2'b00;
    rsp_ready_in = 2'b00;
    set_req(0, 0, 0, 0);
    set_req(1, 0, 0, 0);
    repeat (2) @(negedge clk_in);
    #1;
    check("rst_ready", req_ready_out, 0);
    check("rst_rsp_valid", rsp_valid_out, 0);
    check("rst_result", rsp_result_out, 0);
    check("rst_err", rsp_err_out, 0);
    check("rst_alu_en", alu_en_out, 0);
    check("rst_alu_op1", alu_op1_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_count", op_count_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Both valid from reset: req0 MUL 12*3 first, then req1 SUB 20-5
    set_req(0, 8'd12, 8'd3, 4'd2);
    set_req(1, 8'd20, 8'd5, 4'd1);
    req_valid_in = 2'b11;
    do_txn(0, 0, g);
    check("first_winner", g, 0);
    req_valid_in = 2'b10;
    do_txn(0, 0, g);
    check("second_winner", g, 1);

    // Single core request ADD 15+10
    set_req(0, 8'd15, 8'd10, 4'd0);
    req_valid_in = 2'b01;
    do_txn(0, 0, g);

    // Fairness: both held valid for 4 operations
    req_valid_in = 2'b11;
    prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_txn(0, 0, g);
      check("rr_alternate", g, !prev);
      prev = g;
    end

    // Error interception, then a legal divide
    req_valid_in = 2'b01;
    set_req(0, 8'd22, 8'd0, 4'd3);
    do_txn(0, 0, g);
    set_req(0, 8'd22, 8'd5, 4'b1100);
    do_txn(0, 0, g);
    set_req(0, 8'd22, 8'd5, 4'd3);
    do_txn(0, 0, g);

    // Backpressure: req1 wins, its response is held 5 cycles with req0 pending
    set_req(1, 8'd100, 8'd7, 4'd7);
    req_valid_in = 2'b11;
    do_txn(5, 0, g);
    check("bp_owner", g, 1);
    do_txn(0, 0, g);
    check("after_bp_owner", g, 0);

    // Randomized transactions
    for (int i = 0; i < 30; i++) begin
      req_valid_in = 2'($urandom_range(1, 3));
      do_txn($urandom_range(0, 3), 1, g);
    end

    // Reset during EXEC abandons the operation
    set_req(0, 8'd9, 8'd9, 4'd0);
    req_valid_in = 2'b11;
    #1;
    @(negedge clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("mid_rst_alu_en", alu_en_out, 0);
    check("mid_rst_busy", busy_out, 0);
    check("mid_rst_ready", req_ready_out, 0);
    check("mid_rst_count", op_count_out, 0);
    check("mid_rst_alu_op1", alu_op1_out, 0);
    @(negedge clk_in);
    #1;
    check("mid_rst_no_rsp", rsp_valid_out, 0);
    m_last  = 1'b1;
    m_count = 0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    set_req(0, 8'd4, 8'd6, 4'd2);
    set_req(1, 8'd8, 8'd2, 4'd1);
    req_valid_in = 2'b11;
    do_txn(0, 0, g);
    check("post_rst_winner", g, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
